aclk_snooze_ctrl: RTL and testbench

ACLK_SNOOZE_CTRL -- requirements
Module: aclk_snooze_ctrl

---
 rtl/aclk_pkg.sv | 22 ++
 rtl/aclk_tick_timer.sv | 34 +++
 rtl/aclk_snooze_ctrl.sv | 128 ++++++++++++
 tb/tb_aclk_snooze_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/aclk_pkg.sv
// rtl/aclk_pkg.sv - shared types and defaults for the alarm snooze controller
package aclk_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RINGING = 2'd1,
      ST_SNOOZED = 2'd2,
      ST_DONE    = 2'd3
   } snz_state_t;

   localparam int DEF_SNOOZE_TICKS = 3000;
   localparam int DEF_RING_TICKS   = 600;
   localparam int DEF_MAX_SNOOZE   = 3;
   localparam int BEEP_PERIOD      = 10;
   localparam int BEEP_ON          = 5;

   // $clog2(1) is 0, so keep every counter at least one bit wide
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/aclk_tick_timer.sv
// rtl/aclk_tick_timer.sv - clearable tick counter with terminal-count flag
module aclk_tick_timer #(
   parameter int WIDTH = 4,
   parameter int LIMIT = 10,
   parameter bit WRAP  = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             enable,
   output logic [WIDTH-1:0] count,
   output logic             tc
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

   assign tc = (count == LAST);

   // Non-wrapping timers hold at the terminal value instead of overflowing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         if (!tc) begin
            count <= count + 1'b1;
         end else if (WRAP) begin
            count <= '0;
         end
      end
   end

endmodule

// File: rtl/aclk_snooze_ctrl.sv
// rtl/aclk_snooze_ctrl.sv - alarm ring/snooze/stop sequencer with beeping buzzer
module aclk_snooze_ctrl
   import aclk_pkg::*;
#(
   parameter int SNOOZE_TICKS = DEF_SNOOZE_TICKS,
   parameter int RING_TICKS   = DEF_RING_TICKS,
   parameter int MAX_SNOOZE   = DEF_MAX_SNOOZE
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       Alarm,
   input  logic       AL_ON,
   input  logic       STOP_al,
   input  logic       SNOOZE,
   output logic       BUZZ,
   output logic       SNOOZING,
   output logic [2:0] snooze_cnt
);

   localparam int RING_W  = cnt_w(RING_TICKS);
   localparam int SNZ_W   = cnt_w(SNOOZE_TICKS);
   localparam int PHASE_W = cnt_w(BEEP_PERIOD);
   localparam logic [2:0]         MAX_CNT  = 3'(MAX_SNOOZE);
   localparam logic [PHASE_W-1:0] BEEP_END = PHASE_W'(BEEP_ON);

   snz_state_t state, next_state;

   logic alarm_q;
   logic armed;
   logic alarm_rise;

   logic               ringing, snoozed;
   logic               ring_tc, snz_tc, phase_tc_unused;
   logic [RING_W-1:0]  unused_ring_count;
   logic [SNZ_W-1:0]   unused_snz_count;
   logic [PHASE_W-1:0] phase;

   logic       buzz_d;
   logic       snoozing_d;
   logic [2:0] cnt_d;

   // armed stays low for the first cycle after reset so a held Alarm is not a rise
   assign alarm_rise = Alarm & ~alarm_q & armed;
   assign ringing    = (state == ST_RINGING);
   assign snoozed    = (state == ST_SNOOZED);

   aclk_tick_timer #(.WIDTH(RING_W), .LIMIT(RING_TICKS), .WRAP(1'b0)) u_ring_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (!ringing),
      .enable (ringing),
      .count  (unused_ring_count),
      .tc     (ring_tc)
   );

   aclk_tick_timer #(.WIDTH(SNZ_W), .LIMIT(SNOOZE_TICKS), .WRAP(1'b0)) u_snooze_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (!snoozed),
      .enable (snoozed),
      .count  (unused_snz_count),
      .tc     (snz_tc)
   );

   aclk_tick_timer #(.WIDTH(PHASE_W), .LIMIT(BEEP_PERIOD), .WRAP(1'b1)) u_phase_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (!ringing),
      .enable (ringing),
      .count  (phase),
      .tc     (phase_tc_unused)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         alarm_q    <= 1'b0;
         armed      <= 1'b0;
         BUZZ       <= 1'b0;
         SNOOZING   <= 1'b0;
         snooze_cnt <= 3'd0;
      end else begin
         state      <= next_state;
         alarm_q    <= Alarm;
         armed      <= 1'b1;
         BUZZ       <= buzz_d;
         SNOOZING   <= snoozing_d;
         snooze_cnt <= cnt_d;
      end
   end

   // Priority: AL_ON low, then STOP_al, then SNOOZE, then timer expiry
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (alarm_rise) next_state = ST_RINGING;
         end
         ST_RINGING: begin
            if (STOP_al)                           next_state = ST_DONE;
            else if (SNOOZE && snooze_cnt < MAX_CNT) next_state = ST_SNOOZED;
            else if (ring_tc)                      next_state = ST_DONE;
         end
         ST_SNOOZED: begin
            if (STOP_al)     next_state = ST_DONE;
            else if (snz_tc) next_state = ST_RINGING;
         end
         ST_DONE: begin
            if (!Alarm) next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
      if (!AL_ON) next_state = ST_IDLE;
   end

   // Beep only while staying in RINGING so stop/snooze/disable silence the next cycle
   always_comb begin
      buzz_d     = ringing && (next_state == ST_RINGING) && (phase < BEEP_END);
      snoozing_d = (next_state == ST_SNOOZED);
      cnt_d      = snooze_cnt;
      if (next_state == ST_IDLE) begin
         cnt_d = 3'd0;
      end else if (ringing && next_state == ST_SNOOZED) begin
         cnt_d = snooze_cnt + 3'd1;
      end
   end

endmodule

// File: tb/tb_aclk_snooze_ctrl.sv
// tb/tb_aclk_snooze_ctrl.sv - directed self-checking bench for aclk_snooze_ctrl
module tb_aclk_snooze_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       Alarm, AL_ON, STOP_al, SNOOZE;
   logic       BUZZ, SNOOZING;
   logic [2:0] snooze_cnt;

   int errors = 0;
   int checks = 0;

   aclk_snooze_ctrl #(.SNOOZE_TICKS(20), .RING_TICKS(30), .MAX_SNOOZE(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .Alarm      (Alarm),
      .AL_ON      (AL_ON),
      .STOP_al    (STOP_al),
      .SNOOZE     (SNOOZE),
      .BUZZ       (BUZZ),
      .SNOOZING   (SNOOZING),
      .snooze_cnt (snooze_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; Alarm = 1'b0; AL_ON = 1'b0; STOP_al = 1'b0; SNOOZE = 1'b0;
      step(); step();
      check("rst_buzz", 8'(BUZZ), 8'd0);
      check("rst_snoozing", 8'(SNOOZING), 8'd0);
      check("rst_cnt", 8'(snooze_cnt), 8'd0);
      rst_n = 1'b1;
      step();
      AL_ON = 1'b1;
      step();

      // basic ring: 5 on / 5 off, auto-stop after 30 cycles
      Alarm = 1'b1;
      step();
      check("ring_entry_buzz", 8'(BUZZ), 8'd0);
      for (int j = 1; j <= 30; j++) begin
         step();
         check($sformatf("ring_pattern_%0d", j), 8'(BUZZ), 8'(((j - 1) % 10) < 5));
      end
      for (int j = 0; j < 12; j++) begin
         step();
         check("done_silent", 8'(BUZZ), 8'd0);
      end
      Alarm = 1'b0;
      step();
      check("idle_cnt", 8'(snooze_cnt), 8'd0);

      // snooze once, resume 20 cycles later; held SNOOZE ignored while snoozed
      Alarm = 1'b1;
      step();
      step();
      check("ring2_buzz", 8'(BUZZ), 8'd1);
      SNOOZE = 1'b1;
      step();
      check("snz1_buzz", 8'(BUZZ), 8'd0);
      check("snz1_snoozing", 8'(SNOOZING), 8'd1);
      check("snz1_cnt", 8'(snooze_cnt), 8'd1);
      for (int i = 1; i <= 19; i++) begin
         step();
         check("snz1_hold_snoozing", 8'(SNOOZING), 8'd1);
         check("snz1_hold_buzz", 8'(BUZZ), 8'd0);
         check("snz1_hold_cnt", 8'(snooze_cnt), 8'd1);
         if (i == 10) SNOOZE = 1'b0;
      end
      step();
      check("resume_snoozing", 8'(SNOOZING), 8'd0);
      check("resume_buzz0", 8'(BUZZ), 8'd0);
      step();
      check("resume_buzz1", 8'(BUZZ), 8'd1);

      // second snooze reaches the limit, third request is ignored
      SNOOZE = 1'b1;
      step();
      SNOOZE = 1'b0;
      check("snz2_cnt", 8'(snooze_cnt), 8'd2);
      check("snz2_snoozing", 8'(SNOOZING), 8'd1);
      for (int i = 1; i <= 20; i++) step();
      check("resume2_snoozing", 8'(SNOOZING), 8'd0);
      step();
      check("resume2_buzz", 8'(BUZZ), 8'd1);
      SNOOZE = 1'b1;
      step();
      SNOOZE = 1'b0;
      check("snz3_cnt", 8'(snooze_cnt), 8'd2);
      check("snz3_snoozing", 8'(SNOOZING), 8'd0);
      check("snz3_buzz", 8'(BUZZ), 8'd1);
      STOP_al = 1'b1;
      step();
      STOP_al = 1'b0;
      check("stop_buzz", 8'(BUZZ), 8'd0);
      check("stop_cnt_kept", 8'(snooze_cnt), 8'd2);
      Alarm = 1'b0;
      step();
      check("stop_idle_cnt", 8'(snooze_cnt), 8'd0);

      // STOP_al and SNOOZE together: stop wins
      Alarm = 1'b1;
      step();
      step();
      check("ring4_buzz", 8'(BUZZ), 8'd1);
      STOP_al = 1'b1; SNOOZE = 1'b1;
      step();
      STOP_al = 1'b0; SNOOZE = 1'b0;
      check("both_buzz", 8'(BUZZ), 8'd0);
      check("both_snoozing", 8'(SNOOZING), 8'd0);
      check("both_cnt", 8'(snooze_cnt), 8'd0);
      for (int j = 0; j < 12; j++) begin
         step();
         check("both_done_buzz", 8'(BUZZ), 8'd0);
         check("both_done_snoozing", 8'(SNOOZING), 8'd0);
      end
      Alarm = 1'b0;
      step();

      // AL_ON dropped while snoozed
      Alarm = 1'b1;
      step();
      SNOOZE = 1'b1;
      step();
      SNOOZE = 1'b0;
      check("snz5_cnt", 8'(snooze_cnt), 8'd1);
      step(); step(); step();
      AL_ON = 1'b0;
      step();
      check("aloff_cnt", 8'(snooze_cnt), 8'd0);
      check("aloff_snoozing", 8'(SNOOZING), 8'd0);
      check("aloff_buzz", 8'(BUZZ), 8'd0);
      AL_ON = 1'b1;
      for (int j = 0; j < 40; j++) begin
         step();
         check("aloff_no_ring", 8'(BUZZ), 8'd0);
         check("aloff_no_snooze", 8'(SNOOZING), 8'd0);
      end
      Alarm = 1'b0;
      step();

      // asynchronous reset mid-ring with Alarm held high
      Alarm = 1'b1;
      step();
      step();
      check("ring6_buzz", 8'(BUZZ), 8'd1);
      step();
      rst_n = 1'b0;
      #1;
      check("async_rst_buzz", 8'(BUZZ), 8'd0);
      step();
      check("rst6_cnt", 8'(snooze_cnt), 8'd0);
      check("rst6_snoozing", 8'(SNOOZING), 8'd0);
      rst_n = 1'b1;
      for (int j = 0; j < 30; j++) begin
         step();
         check("held_no_ring", 8'(BUZZ), 8'd0);
      end
      Alarm = 1'b0;
      step();
      Alarm = 1'b1;
      step();
      check("rering_entry", 8'(BUZZ), 8'd0);
      step();
      check("rering_buzz", 8'(BUZZ), 8'd1);

      // rise while disabled is ignored even after re-enabling
      AL_ON = 1'b0;
      step();
      check("dis_buzz", 8'(BUZZ), 8'd0);
      Alarm = 1'b0;
      step();
      Alarm = 1'b1;
      step();
      AL_ON = 1'b1;
      for (int j = 0; j < 12; j++) begin
         step();
         check("dis_rise_ignored", 8'(BUZZ), 8'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
